v2f_divmod_seq: RTL and testbench



---
 rtl/v2f_divmod_seq.sv | 157 +++++++++++++++
 tb/tb_v2f_divmod_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/v2f_divmod_seq.sv
// Multi-cycle restoring divider: truncating quotient, dividend-signed remainder.
// x/0 and x%0 give 0 with div_zero set; valid/ready handshake on both sides.
module v2f_divmod_seq #(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int Y_WIDTH = 8,
    parameter bit SIGNED  = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Y_WIDTH-1:0] Q,
    output logic [Y_WIDTH-1:0] R,
    output logic               div_zero
);
    localparam int N  = (A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t         r_state;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [Y_WIDTH-1:0] r_q;
    logic [Y_WIDTH-1:0] r_r;
    logic           r_dz;
    logic [CW-1:0]  r_cnt;
    logic [N:0]     r_rem;
    logic [N-1:0]   r_quo;
    logic [N-1:0]   r_div;
    logic           r_a_neg;
    logic           r_q_neg;

    logic [N-1:0]   w_a_ext;
    logic [N-1:0]   w_b_ext;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [N-1:0]   w_a_mag;
    logic [N-1:0]   w_b_mag;
    logic           w_b_zero;
    logic [N:0]     w_sh;
    logic [N:0]     w_sub;
    logic           w_ge;
    logic [N-1:0]   w_q_n;
    logic [N-1:0]   w_r_n;
    logic [Y_WIDTH-1:0] w_q_y;
    logic [Y_WIDTH-1:0] w_r_y;

    generate
        if (SIGNED) begin : g_sx
            assign w_a_ext = N'(signed'(A));
            assign w_b_ext = N'(signed'(B));
            assign w_q_y   = Y_WIDTH'(signed'(w_q_n));
            assign w_r_y   = Y_WIDTH'(signed'(w_r_n));
        end else begin : g_zx
            assign w_a_ext = N'(A);
            assign w_b_ext = N'(B);
            assign w_q_y   = Y_WIDTH'(w_q_n);
            assign w_r_y   = Y_WIDTH'(w_r_n);
        end
    endgenerate

    assign w_a_neg  = SIGNED & w_a_ext[N-1];
    assign w_b_neg  = SIGNED & w_b_ext[N-1];
    assign w_a_mag  = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag  = w_b_neg ? -w_b_ext : w_b_ext;
    assign w_b_zero = (w_b_ext == '0);

    // Partial remainder never exceeds 2*divisor, so N+1 bits hold the trial.
    assign w_sh  = {r_rem[N-1:0], r_quo[N-1]};
    assign w_sub = w_sh - {1'b0, r_div};
    assign w_ge  = ~w_sub[N];

    assign w_q_n = r_q_neg ? -r_quo : r_quo;
    assign w_r_n = r_a_neg ? -r_rem[N-1:0] : r_rem[N-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q         <= '0;
            r_r         <= '0;
            r_dz        <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_a_neg     <= 1'b0;
            r_q_neg     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_neg    <= w_a_neg;
                        r_q_neg    <= w_a_neg ^ w_b_neg;
                        r_quo      <= w_a_mag;
                        r_div      <= w_b_mag;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (w_b_zero) begin
                            r_q         <= '0;
                            r_r         <= '0;
                            r_dz        <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_ge ? w_sub : w_sh;
                    r_quo <= {r_quo[N-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_q         <= w_q_y;
                    r_r         <= w_r_y;
                    r_dz        <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Q         = r_q;
    assign R         = r_r;
    assign div_zero  = r_dz;
endmodule

// File: tb/tb_v2f_divmod_seq.sv
// Directed bench for v2f_divmod_seq: unsigned 8b, signed 8b, signed 8b->16b.
// Expected values are hand-computed constants.
module tb_v2f_divmod_seq;
    logic       clk;
    logic       rst_n;
    logic [2:0] iv;
    logic [2:0] ir;
    logic [2:0] ov;
    logic [2:0] ordy;
    logic [2:0] dz;
    logic [7:0] a [3];
    logic [7:0] b [3];
    logic [7:0] q0, r0, q1, r1;
    logic [15:0] q2, r2;

    int total;
    int bad;

    v2f_divmod_seq #(.A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(8), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .A(a[0]), .B(b[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .Q(q0), .R(r0), .div_zero(dz[0])
    );

    v2f_divmod_seq #(.A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(8), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .A(a[1]), .B(b[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .Q(q1), .R(r1), .div_zero(dz[1])
    );

    v2f_divmod_seq #(.A_WIDTH(8), .B_WIDTH(8), .Y_WIDTH(16), .SIGNED(1'b1)) u_wid (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]), .A(a[2]), .B(b[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .Q(q2), .R(r2), .div_zero(dz[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] get_q(input int d);
        case (d)
            0: get_q = {8'h00, q0};
            1: get_q = {8'h00, q1};
            default: get_q = q2;
        endcase
    endfunction

    function automatic logic [15:0] get_r(input int d);
        case (d)
            0: get_r = {8'h00, r0};
            1: get_r = {8'h00, r1};
            default: get_r = r2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input int d, input logic [7:0] av,
                            input logic [7:0] bv);
        @(negedge clk);
        chk("in_ready_before", 32'(ir[d]), 32'd1);
        a[d]  = av;
        b[d]  = bv;
        iv[d] = 1'b1;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    // Latency counts edges from the accepting edge inclusive.
    task automatic wait_out(input int d, output int lat);
        lat = 1;
        while (!ov[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic op(input string tag, input int d,
                      input logic [7:0] av, input logic [7:0] bv,
                      input logic [15:0] eq, input logic [15:0] er,
                      input logic edz, input int elat);
        int lat;
        ordy[d] = 1'b1;
        start_op(d, av, bv);
        wait_out(d, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(get_q(d)), 32'(eq));
        chk({tag, "_r"}, 32'(get_r(d)), 32'(er));
        chk({tag, "_dz"}, 32'(dz[d]), 32'(edz));
        @(posedge clk);
        #1;
        chk({tag, "_ov_clr"}, 32'(ov[d]), 32'd0);
        chk({tag, "_rdy"}, 32'(ir[d]), 32'd1);
    endtask

    initial begin
        int lat;
        int cnt;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        iv    = '0;
        ordy  = '1;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(ir), 32'h7);
        chk("rst_ov", 32'(ov), 32'h0);
        chk("rst_dz", 32'(dz), 32'h0);
        chk("rst_q", 32'({q0, q1}), 32'h0);
        chk("rst_q16", 32'(q2), 32'h0);
        chk("rst_r16", 32'(r2), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        op("u100_7", 0, 8'd100, 8'd7, 16'd14, 16'd2, 1'b0, 10);
        op("sm7_2", 1, 8'hF9, 8'h02, 16'h00FD, 16'h00FF, 1'b0, 10);
        op("s7_m2", 1, 8'h07, 8'hFE, 16'h00FD, 16'h0001, 1'b0, 10);
        op("sm7_m2", 1, 8'hF9, 8'hFE, 16'h0003, 16'h00FF, 1'b0, 10);
        op("u55_0", 0, 8'd55, 8'd0, 16'd0, 16'd0, 1'b1, 1);
        op("u9_3", 0, 8'd9, 8'd3, 16'd3, 16'd0, 1'b0, 10);
        op("s55_0", 1, 8'd55, 8'd0, 16'd0, 16'd0, 1'b1, 1);
        op("s9_3", 1, 8'd9, 8'd3, 16'd3, 16'd0, 1'b0, 10);
        op("sovf", 1, 8'h80, 8'hFF, 16'h0080, 16'h0000, 1'b0, 10);
        op("wovf", 2, 8'h80, 8'hFF, 16'hFF80, 16'h0000, 1'b0, 10);
        op("wm7_2", 2, 8'hF9, 8'h02, 16'hFFFD, 16'hFFFF, 1'b0, 10);
        op("u0_5", 0, 8'd0, 8'd5, 16'd0, 16'd0, 1'b0, 10);
        op("s5_m9", 1, 8'd5, 8'hF7, 16'd0, 16'd5, 1'b0, 10);
        op("u255_16", 0, 8'd255, 8'd16, 16'd15, 16'd15, 1'b0, 10);

        ordy[0] = 1'b0;
        start_op(0, 8'd200, 8'd3);
        wait_out(0, lat);
        chk("bp_lat", 32'(lat), 32'd10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a[0]  = 8'd1;
            b[0]  = 8'd1;
            iv[0] = 1'b1;
            @(posedge clk);
            #1;
            iv[0] = 1'b0;
            chk("bp_q", 32'(q0), 32'd66);
            chk("bp_r", 32'(r0), 32'd2);
            chk("bp_ov", 32'(ov[0]), 32'd1);
            chk("bp_rdy", 32'(ir[0]), 32'd0);
        end
        @(negedge clk);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ov_clr", 32'(ov[0]), 32'd0);
        chk("bp_rdy_idle", 32'(ir[0]), 32'd1);
        chk("bp_q_hold", 32'(q0), 32'd66);
        cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ov[0]) cnt++;
        end
        chk("bp_one_hs", 32'(cnt), 32'd0);

        start_op(0, 8'd100, 8'd7);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(ir[0]), 32'd1);
        chk("mid_rst_ov", 32'(ov[0]), 32'd0);
        chk("mid_rst_q", 32'(q0), 32'd0);
        chk("mid_rst_r", 32'(r0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (ov[0]) cnt++;
        end
        chk("mid_rst_no_ov", 32'(cnt), 32'd0);
        op("u9_4", 0, 8'd9, 8'd4, 16'd2, 16'd1, 1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
